// File: rtl/fpfix_to_float_seq.sv
// Sequential signed fixed-point to FloPoCo float converter.
// The magnitude is normalised by one left shift per clock, with valid/ready on both sides.
module fpfix_to_float_seq #(
    parameter int WIN = 7,
    parameter int LSB = -3,
    parameter int WE  = 8,
    parameter int WF  = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIN-1:0]      in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WE+WF+2:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int KW       = $clog2(WIN);
    localparam int EXP_BASE = (2 ** (WE - 1)) - 1 + (WIN - 1 + LSB);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [WIN-1:0]       mag_q, mag_d;
    logic [KW-1:0]        k_q, k_d;
    logic [WE+WF+2:0]     out_data_q, out_data_d;

    logic [WE-1:0]        exp_w;
    logic [WF-1:0]        frac_w;

    // The leading one is implicit, so only the bits below it land in the fraction.
    assign exp_w  = WE'(EXP_BASE - int'(k_q));
    assign frac_w = WF'(mag_q[WIN-2:0]) << (WF - WIN + 1);

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path can infer a latch.
        state_d    = state_q;
        sign_d     = sign_q;
        mag_d      = mag_q;
        k_d        = k_q;
        out_data_d = out_data_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_d  = in_data[WIN-1];
                    // -2^(WIN-1) negates to itself, which is the correct unsigned magnitude.
                    mag_d   = in_data[WIN-1] ? -in_data : in_data;
                    k_d     = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0) begin
                    out_data_d = '0;
                    state_d    = DONE;
                end else if (mag_q[WIN-1]) begin
                    out_data_d = {2'b01, sign_q, exp_w, frac_w};
                    state_d    = DONE;
                end else begin
                    mag_d = mag_q << 1;
                    k_d   = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            // NOTE: the working registers are reset too; it is a handful of flops, not a memory.
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            k_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            mag_q      <= mag_d;
            k_q        <= k_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fpfix_to_float_seq.sv
// Directed and exhaustive checks of fpfix_to_float_seq in its default Q3.3 -> FloPoCo(8,23) format.
module tb_fpfix_to_float_seq;

    logic        clk;
    logic        rst;
    logic [6:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_cmp;
    int n_err;

    fpfix_to_float_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = d * 2^-3; exponent from the position of the leading one of |d|.
    function automatic int msb_pos(input int m);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (((m >> i) & 1) == 1) p = i;
        end
        return p;
    endfunction

    function automatic logic [33:0] ref_data(input logic [6:0] d);
        int          v, m, p;
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        v = int'($signed(d));
        if (v == 0) return 34'h0;
        s = (v < 0);
        m = s ? -v : v;
        p = msb_pos(m);
        e = 8'(127 + p - 3);
        f = 23'((m - (1 << p)) << (23 - p));
        return {2'b01, s, e, f};
    endfunction

    function automatic int ref_lat(input logic [6:0] d);
        int v, m;
        v = int'($signed(d));
        if (v == 0) return 2;
        m = (v < 0) ? -v : v;
        return 2 + (6 - msb_pos(m));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents d and returns #1 after the accepting edge, with in_data scrambled.
    task automatic do_accept(input logic [6:0] d);
        int t;
        in_data  = d;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, t);
        end
        step();
        in_valid = 1'b0;
        in_data  = 7'($urandom);
    endtask

    // Called #1 after the accepting edge, i.e. in cycle c0+1.
    task automatic wait_result(input logic [33:0] exp_data, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat <= 20) begin
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, exp_lat);
        end
        n_cmp++;
        if (out_data !== exp_data) begin
            n_err++;
            $display("FAIL out_data: got 0x%09h, required 0x%09h", out_data, exp_data);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 7'h0;
        out_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 34'h0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: out_valid=%b out_data=0x%09h in_ready=%b, required 0/0/0",
                     out_valid, out_data, in_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [6:0]  vec_in  [5] = '{7'b0001000, 7'b1000000, 7'b1101011, 7'b0000001, 7'b0000000};
        logic [33:0] vec_out [5] = '{34'h13F800000, 34'h1C1000000, 34'h1C0280000, 34'h13E000000, 34'h000000000};
        int          vec_lat [5] = '{5, 2, 4, 8, 2};
        for (int i = 0; i < 5; i++) begin
            do_accept(vec_in[i]);
            wait_result(vec_out[i], vec_lat[i]);
            release_result();
        end
    endtask

    task automatic test_backpressure();
        do_accept(7'b0001000);
        wait_result(34'h13F800000, 5);
        in_data  = 7'b1000000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (out_data !== 34'h13F800000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: out_data=0x%09h out_valid=%b in_ready=%b", i, out_data,
                         out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
        end
        do_accept(7'b1000000);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL busy_in_ready: in_ready=%b, required 0", in_ready);
        end
        wait_result(34'h1C1000000, 2);
        release_result();
    endtask

    task automatic test_reset_mid();
        bit seen_valid;
        do_accept(7'b0000001);
        step();
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b, required 0 and 0", out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_data !== 34'h0) begin
            n_err++;
            $display("FAIL mid_reset_idle: in_ready=%b out_data=0x%09h, required 1 and 0", in_ready, out_data);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        n_cmp++;
        if (seen_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_emit: out_valid seen=%b, required 0", seen_valid);
        end
        do_accept(7'b1101011);
        wait_result(34'h1C0280000, 4);
        release_result();
    endtask

    task automatic test_sweep();
        logic [6:0]  d;
        logic [33:0] held;
        int          stall;
        for (int i = 0; i < 128; i++) begin
            d = 7'(i);
            do_accept(d);
            wait_result(ref_data(d), ref_lat(d));
            held  = out_data;
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) begin
                step();
                n_cmp++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL sweep_stall[%0d]: out_data=0x%09h out_valid=%b", i, out_data, out_valid);
                end
            end
            release_result();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
